mc_ctrl_fsm: RTL and testbench

//  Multi-cycle control FSM for the MIPS core. Sequences one shared ALU, the gpr file, pc and a unified

---
 rtl/mc_ctrl_fsm.sv | 212 +++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared ALU and unified memory, producing every datapath enable and mux select.
module mc_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       halted,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state, state_next;
  logic [7:0] wait_cnt, wait_cnt_next;
  logic [1:0] err, err_next;
  logic [5:0] op_lat, fn_lat;
  logic       legal;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                        (funct == FN_OR)  || (funct == FN_SLT);
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
      default:  legal = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
      err      <= 2'd0;
      op_lat   <= 6'd0;
      fn_lat   <= 6'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      err      <= err_next;
      if (state == S_DECODE) begin
        op_lat <= opcode;
        fn_lat <= funct;
      end
    end
  end

  always_comb begin
    state_next    = state;
    err_next      = err;
    wait_cnt_next = 8'd0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = ALU_ADD;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    halted        = 1'b0;
    err_code      = 2'd0;

    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else if (wait_cnt == TIMEOUT) begin
          state_next = S_HALT;
          err_next   = 2'd2;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        if (!legal) begin
          state_next = S_HALT;
          err_next   = 2'd1;
        end else if (opcode == OP_J) begin
          pc_write   = 1'b1;
          pc_src     = 2'd2;
          state_next = S_FETCH;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        case (op_lat)
          OP_RTYPE: begin
            case (fn_lat)
              FN_SUB:  alu_op = ALU_SUB;
              FN_AND:  alu_op = ALU_AND;
              FN_OR:   alu_op = ALU_OR;
              FN_SLT:  alu_op = ALU_SLT;
              default: alu_op = ALU_ADD;
            endcase
            state_next = S_WB;
          end
          OP_BEQ: begin
            alu_op     = ALU_SUB;
            pc_src     = 2'd1;
            pc_write   = zero;
            state_next = S_FETCH;
          end
          OP_ADDI: begin
            alu_src_b  = 2'd2;
            state_next = S_WB;
          end
          default: begin
            alu_src_b  = 2'd2;
            state_next = S_MEM;
          end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = (op_lat == OP_SW);
        if (mem_ready) begin
          state_next = (op_lat == OP_SW) ? S_FETCH : S_WB;
        end else if (wait_cnt == TIMEOUT) begin
          state_next = S_HALT;
          err_next   = 2'd2;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_lat == OP_RTYPE);
        mem_to_reg = (op_lat == OP_LW);
        state_next = S_FETCH;
      end
      default: begin
        halted   = 1'b1;
        err_code = err;
      end
    endcase

    // Counter runs only while stalled in a memory state; any exit or entry restarts it.
    if ((state == S_FETCH || state == S_MEM) && !mem_ready && state_next == state)
      wait_cnt_next = wait_cnt + 8'd1;

    // Outputs are forced idle for the whole reset pulse so an in-flight access drops at once.
    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = ALU_ADD;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      halted     = 1'b0;
      err_code   = 2'd0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: walks each instruction class cycle by cycle and
// compares the full output vector against hand-written per-state expectations.
module tb_mc_ctrl_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       reg_write, reg_dst, mem_to_reg, halted;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  mc_ctrl_fsm #(.MEM_TIMEOUT(5)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .halted(halted), .err_code(err_code)
  );

  always #5 clock = ~clock;

  logic [18:0] obs;
  assign obs = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                alu_op, reg_write, reg_dst, mem_to_reg, halted, err_code};

  function automatic logic [18:0] v(input logic rq, input logic we, input logic iod,
                                    input logic irw, input logic pcw, input logic [1:0] ps,
                                    input logic sa, input logic [1:0] sb, input logic [2:0] op,
                                    input logic rw, input logic rd, input logic m2r,
                                    input logic h, input logic [1:0] e);
    return {rq, we, iod, irw, pcw, ps, sa, sb, op, rw, rd, m2r, h, e};
  endfunction

  logic [18:0] f_rdy, f_wait, dec, dec_j, ex_i, mem_rd, mem_wr, wb_r, wb_i, wb_lw;
  logic [18:0] halt1, halt2, idle;

  task automatic chk(input string tag, input logic [18:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1: drive this cycle's inputs, check settled outputs, advance one clock.
  task automatic cyc(input string tag, input logic rdy, input logic [5:0] op,
                     input logic [5:0] fn, input logic z, input logic [18:0] exp);
    mem_ready = rdy;
    opcode    = op;
    funct     = fn;
    zero      = z;
    #1;
    chk(tag, exp);
    $display("step %-12s t=%0t outputs=%05h", tag, $time, obs);
    @(posedge clock);
    #1;
  endtask

  logic [5:0] fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [2:0] op_tab [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

  initial begin
    f_rdy  = v(1,0,0,1,1,2'd0,0,2'd1,3'd0,0,0,0,0,2'd0);
    f_wait = v(1,0,0,0,0,2'd0,0,2'd1,3'd0,0,0,0,0,2'd0);
    dec    = v(0,0,0,0,0,2'd0,0,2'd3,3'd0,0,0,0,0,2'd0);
    dec_j  = v(0,0,0,0,1,2'd2,0,2'd3,3'd0,0,0,0,0,2'd0);
    ex_i   = v(0,0,0,0,0,2'd0,1,2'd2,3'd0,0,0,0,0,2'd0);
    mem_rd = v(1,0,1,0,0,2'd0,0,2'd0,3'd0,0,0,0,0,2'd0);
    mem_wr = v(1,1,1,0,0,2'd0,0,2'd0,3'd0,0,0,0,0,2'd0);
    wb_r   = v(0,0,0,0,0,2'd0,0,2'd0,3'd0,1,1,0,0,2'd0);
    wb_i   = v(0,0,0,0,0,2'd0,0,2'd0,3'd0,1,0,0,0,2'd0);
    wb_lw  = v(0,0,0,0,0,2'd0,0,2'd0,3'd0,1,0,1,0,2'd0);
    halt1  = v(0,0,0,0,0,2'd0,0,2'd0,3'd0,0,0,0,1,2'd1);
    halt2  = v(0,0,0,0,0,2'd0,0,2'd0,3'd0,0,0,0,1,2'd2);
    idle   = '0;

    // Reset held, memory claiming ready: everything must stay quiet.
    mem_ready = 1'b1;
    #3;
    chk("reset_idle", idle);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // R-type over every legal funct; opcode input scrambled after DECODE to prove latching.
    for (int i = 0; i < 5; i++) begin
      cyc("r_fetch", 1'b1, 6'h00, fn_tab[i], 1'b0, f_rdy);
      cyc("r_decode", 1'b1, 6'h00, fn_tab[i], 1'b0, dec);
      cyc("r_exec", 1'b1, 6'h3F, 6'h00, 1'b0,
          v(0,0,0,0,0,2'd0,1,2'd0,op_tab[i],0,0,0,0,2'd0));
      cyc("r_wb", 1'b0, 6'h3F, 6'h00, 1'b0, wb_r);
    end

    // lw with three wait cycles in MEM.
    cyc("lw_fetch", 1'b1, 6'h23, 6'h00, 1'b0, f_rdy);
    cyc("lw_decode", 1'b1, 6'h23, 6'h00, 1'b0, dec);
    cyc("lw_exec", 1'b0, 6'h23, 6'h00, 1'b0, ex_i);
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1'b0, 6'h23, 6'h00, 1'b0, mem_rd);
    cyc("lw_mem_ack", 1'b1, 6'h23, 6'h00, 1'b0, mem_rd);
    cyc("lw_wb", 1'b0, 6'h23, 6'h00, 1'b0, wb_lw);

    // sw with zero-wait memory, CPI 4.
    cyc("sw_fetch", 1'b1, 6'h2B, 6'h00, 1'b0, f_rdy);
    cyc("sw_decode", 1'b1, 6'h2B, 6'h00, 1'b0, dec);
    cyc("sw_exec", 1'b0, 6'h2B, 6'h00, 1'b0, ex_i);
    cyc("sw_mem", 1'b1, 6'h2B, 6'h00, 1'b0, mem_wr);

    // beq taken then not taken, CPI 3 each.
    cyc("beq1_fetch", 1'b1, 6'h04, 6'h00, 1'b0, f_rdy);
    cyc("beq1_decode", 1'b1, 6'h04, 6'h00, 1'b0, dec);
    cyc("beq1_exec", 1'b0, 6'h04, 6'h00, 1'b1, v(0,0,0,0,1,2'd1,1,2'd0,3'd1,0,0,0,0,2'd0));
    cyc("beq0_fetch", 1'b1, 6'h04, 6'h00, 1'b0, f_rdy);
    cyc("beq0_decode", 1'b1, 6'h04, 6'h00, 1'b0, dec);
    cyc("beq0_exec", 1'b0, 6'h04, 6'h00, 1'b0, v(0,0,0,0,0,2'd1,1,2'd0,3'd1,0,0,0,0,2'd0));

    // j completes in DECODE; addi goes EXEC -> WB.
    cyc("j_fetch", 1'b1, 6'h02, 6'h00, 1'b0, f_rdy);
    cyc("j_decode", 1'b1, 6'h02, 6'h00, 1'b0, dec_j);
    cyc("addi_fetch", 1'b1, 6'h08, 6'h00, 1'b0, f_rdy);
    cyc("addi_decode", 1'b1, 6'h08, 6'h00, 1'b0, dec);
    cyc("addi_exec", 1'b0, 6'h08, 6'h00, 1'b0, ex_i);
    cyc("addi_wb", 1'b0, 6'h08, 6'h00, 1'b0, wb_i);

    // Fetch stalls 5 cycles, ready arrives as the count hits the limit: no error.
    for (int i = 0; i < 5; i++) cyc("to_ok_wait", 1'b0, 6'h02, 6'h00, 1'b0, f_wait);
    cyc("to_ok_ack", 1'b1, 6'h02, 6'h00, 1'b0, f_rdy);
    cyc("to_ok_decode", 1'b1, 6'h02, 6'h00, 1'b0, dec_j);

    // Reset in the middle of an sw MEM stall drops the request immediately.
    cyc("rst_fetch", 1'b1, 6'h2B, 6'h00, 1'b0, f_rdy);
    cyc("rst_decode", 1'b1, 6'h2B, 6'h00, 1'b0, dec);
    cyc("rst_exec", 1'b0, 6'h2B, 6'h00, 1'b0, ex_i);
    cyc("rst_mem", 1'b0, 6'h2B, 6'h00, 1'b0, mem_wr);
    reset = 1'b1;
    #1;
    chk("rst_async_drop", idle);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc("rst_refetch", 1'b0, 6'h2B, 6'h00, 1'b0, f_wait);
    cyc("rst_refetch2", 1'b1, 6'h08, 6'h00, 1'b0, f_rdy);
    cyc("rst_decode2", 1'b1, 6'h08, 6'h00, 1'b0, dec);
    cyc("rst_exec2", 1'b0, 6'h08, 6'h00, 1'b0, ex_i);
    cyc("rst_wb2", 1'b0, 6'h08, 6'h00, 1'b0, wb_i);

    // Fetch stalls past the limit: halt with err 2, sticky.
    for (int i = 0; i < 6; i++) cyc("to_err_wait", 1'b0, 6'h00, 6'h20, 1'b0, f_wait);
    for (int i = 0; i < 3; i++) cyc("to_err_halt", 1'b1, 6'h00, 6'h20, 1'b1, halt2);

    // Illegal opcode: halt after DECODE with err 1, nothing ever enabled again.
    reset = 1'b1;
    #1;
    chk("ill_reset", idle);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc("ill_fetch", 1'b1, 6'h3F, 6'h00, 1'b0, f_rdy);
    cyc("ill_decode", 1'b1, 6'h3F, 6'h00, 1'b0, dec);
    for (int i = 0; i < 4; i++) cyc("ill_halt", 1'b1, 6'h00, 6'h20, 1'b1, halt1);

    // Illegal funct on an R-type.
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc("illfn_fetch", 1'b1, 6'h00, 6'h21, 1'b0, f_rdy);
    cyc("illfn_decode", 1'b1, 6'h00, 6'h21, 1'b0, dec);
    cyc("illfn_halt", 1'b1, 6'h00, 6'h21, 1'b0, halt1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
